// File: rtl/gb_timer.sv
// Game Boy style DIV/TIMA/TMA/TAC timer with falling-edge TIMA increment,
// delayed overflow reload and a one-clock interrupt request.
module gb_timer #(
   parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_in,
   input  logic        cpu_wren,
   output logic [7:0]  data_out,
   output logic        hit,
   output logic        timer_int
);

   typedef enum logic [1:0] {RUN, OVF_WAIT, RELOAD} state_t;

   state_t      state_q, state_d;
   logic [15:0] sys_cnt_q, sys_cnt_d;
   logic [7:0]  tima_q, tima_d;
   logic [7:0]  tma_q, tma_d;
   logic [2:0]  tac_q, tac_d;
   logic [1:0]  ovf_cnt_q, ovf_cnt_d;
   logic        prev_inc_q;
   logic        timer_int_q, timer_int_d;

   logic [15:0] offs;
   logic        wr_div, wr_tima, wr_tma, wr_tac;
   logic        tap, inc, fall;

   assign offs    = cpu_addr - BASE_ADDR;
   assign hit     = (offs[15:2] == 14'd0);
   assign wr_div  = cpu_wren & hit & (offs[1:0] == 2'd0);
   assign wr_tima = cpu_wren & hit & (offs[1:0] == 2'd1);
   assign wr_tma  = cpu_wren & hit & (offs[1:0] == 2'd2);
   assign wr_tac  = cpu_wren & hit & (offs[1:0] == 2'd3);

   always_comb begin
      case (tac_q[1:0])
         2'b00:   tap = sys_cnt_q[9];
         2'b01:   tap = sys_cnt_q[3];
         2'b10:   tap = sys_cnt_q[5];
         default: tap = sys_cnt_q[7];
      endcase
   end

   assign inc  = tac_q[2] & tap;
   // Any 1->0 of inc counts, including those caused by DIV/TAC writes.
   assign fall = prev_inc_q & ~inc;

   always_comb begin
      sys_cnt_d   = wr_div ? 16'h0000 : sys_cnt_q + 16'd1;
      tma_d       = wr_tma ? cpu_data_in : tma_q;
      tac_d       = wr_tac ? cpu_data_in[2:0] : tac_q;
      tima_d      = tima_q;
      state_d     = state_q;
      ovf_cnt_d   = ovf_cnt_q;
      timer_int_d = 1'b0;
      case (state_q)
         RUN: begin
            if (wr_tima) begin
               tima_d = cpu_data_in;
            end else if (fall) begin
               if (tima_q == 8'hFF) begin
                  tima_d    = 8'h00;
                  state_d   = OVF_WAIT;
                  ovf_cnt_d = 2'd0;
               end else begin
                  tima_d = tima_q + 8'd1;
               end
            end
         end
         OVF_WAIT: begin
            if (wr_tima) begin
               tima_d  = cpu_data_in;
               state_d = RUN;
            end else if (ovf_cnt_q == 2'd3) begin
               tima_d      = tma_d;
               state_d     = RELOAD;
               timer_int_d = 1'b1;
            end else begin
               ovf_cnt_d = ovf_cnt_q + 2'd1;
            end
         end
         RELOAD: begin
            // TIMA tracks TMA (including a same-cycle TMA write); TIMA writes are dropped.
            tima_d  = tma_d;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= RUN;
         sys_cnt_q   <= 16'h0000;
         tima_q      <= 8'h00;
         tma_q       <= 8'h00;
         tac_q       <= 3'b000;
         ovf_cnt_q   <= 2'd0;
         prev_inc_q  <= 1'b0;
         timer_int_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sys_cnt_q   <= sys_cnt_d;
         tima_q      <= tima_d;
         tma_q       <= tma_d;
         tac_q       <= tac_d;
         ovf_cnt_q   <= ovf_cnt_d;
         prev_inc_q  <= inc;
         timer_int_q <= timer_int_d;
      end
   end

   assign timer_int = timer_int_q;

   always_comb begin
      data_out = 8'hFF;
      if (hit) begin
         case (offs[1:0])
            2'd0:    data_out = sys_cnt_q[15:8];
            2'd1:    data_out = tima_q;
            2'd2:    data_out = tma_q;
            default: data_out = {5'b11111, tac_q};
         endcase
      end
   end

endmodule

// File: tb/tb_gb_timer.sv
// Bench for gb_timer: directed vector table, hand-written overflow corner
// sequences and random bus traffic, all checked against a cycle model.
module tb_gb_timer;

   localparam logic [15:0] BASE = 16'hFF04;
   localparam logic [15:0] A_DIV = BASE, A_TIMA = BASE + 16'd1,
                           A_TMA = BASE + 16'd2, A_TAC = BASE + 16'd3;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] cpu_addr = 16'h0000;
   logic [7:0]  cpu_data_in = 8'h00;
   logic        cpu_wren = 1'b0;
   logic [7:0]  data_out;
   logic        hit;
   logic        timer_int;

   gb_timer #(.BASE_ADDR(BASE)) dut (
      .clock(clock), .reset(reset), .cpu_addr(cpu_addr),
      .cpu_data_in(cpu_data_in), .cpu_wren(cpu_wren),
      .data_out(data_out), .hit(hit), .timer_int(timer_int)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] last_rd;
   logic       last_int;

   // Reference model: registers as plain integers, overflow as a countdown.
   int m_cnt, m_tima, m_tma, m_tac, m_wait;
   bit m_prev, m_rel;
   int taps[4] = '{9, 3, 5, 7};

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_hit(input logic [15:0] a);
      return (a >= BASE) && (int'(a) <= int'(BASE) + 3);
   endfunction

   function automatic int m_read(input logic [15:0] a);
      if (!m_hit(a)) return 8'hFF;
      case (int'(a) - int'(BASE))
         0: return (m_cnt >> 8) & 8'hFF;
         1: return m_tima;
         2: return m_tma;
         default: return 8'hF8 | m_tac;
      endcase
   endfunction

   task automatic m_reset();
      m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0;
      m_wait = -1; m_prev = 0; m_rel = 0;
   endtask

   task automatic m_step(input logic [15:0] a, input bit wr, input int d);
      int off;
      bit isw, inc, fall;
      int ntma;
      off  = int'(a) - int'(BASE);
      isw  = wr && m_hit(a);
      inc  = ((m_tac & 4) != 0) && (((m_cnt >> taps[m_tac & 3]) & 1) == 1);
      fall = m_prev && !inc;
      ntma = (isw && off == 2) ? d : m_tma;
      if (m_rel) begin
         m_tima = ntma;
         m_rel  = 0;
      end else if (m_wait >= 0) begin
         if (isw && off == 1) begin
            m_tima = d; m_wait = -1;
         end else if (m_wait == 3) begin
            m_tima = ntma; m_rel = 1; m_wait = -1;
         end else m_wait++;
      end else begin
         if (isw && off == 1) m_tima = d;
         else if (fall) begin
            if (m_tima == 255) begin m_tima = 0; m_wait = 0; end
            else m_tima++;
         end
      end
      m_tma  = ntma;
      m_cnt  = (isw && off == 0) ? 0 : (m_cnt + 1) % 65536;
      if (isw && off == 3) m_tac = d & 7;
      m_prev = inc;
   endtask

   // One bus cycle: drive, compare against the model at negedge, advance at posedge.
   task automatic cyc(input logic [15:0] a, input bit wr, input logic [7:0] d);
      cpu_addr = a; cpu_wren = wr; cpu_data_in = d;
      @(negedge clock);
      last_rd  = data_out;
      last_int = timer_int;
      chk("hit", int'(hit), int'(m_hit(a)));
      chk("data_out", int'(data_out), m_read(a));
      chk("timer_int", int'(timer_int), int'(m_rel));
      @(posedge clock);
      m_step(a, wr, int'(d));
      #1;
      cpu_wren = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      m_reset();
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic setup_ovf(input logic [7:0] tma);
      cyc(A_TAC, 1, 8'h00);
      cyc(A_DIV, 1, 8'h00);
      cyc(A_TAC, 1, 8'h05);
      cyc(A_TMA, 1, tma);
      cyc(A_TIMA, 1, 8'hFE);
   endtask

   task automatic wait_wait1(input string name);
      int n = 0;
      while (m_wait != 1 && n < 100) begin cyc(A_TIMA, 0, 8'h00); n++; end
      chk(name, int'(n < 100), 1);
   endtask

   task automatic wait_rel(input string name);
      int n = 0;
      while (!m_rel && n < 100) begin cyc(A_TIMA, 0, 8'h00); n++; end
      chk(name, int'(n < 100), 1);
   endtask

   typedef struct {
      logic [15:0] addr;
      logic        wr;
      logic [7:0]  wd;
      logic [7:0]  exp_do;
      logic        exp_hit;
   } vec_t;

   vec_t vecs[15];
   logic [7:0] rd[40];
   logic       irq[40];

   initial begin
      vecs[0]  = '{16'hFF05, 0, 8'h00, 8'h00, 1};
      vecs[1]  = '{16'hFF06, 0, 8'h00, 8'h00, 1};
      vecs[2]  = '{16'hFF07, 0, 8'h00, 8'hF8, 1};
      vecs[3]  = '{16'hFF04, 0, 8'h00, 8'h00, 1};
      vecs[4]  = '{16'hFF03, 0, 8'h00, 8'hFF, 0};
      vecs[5]  = '{16'hFF08, 0, 8'h00, 8'hFF, 0};
      vecs[6]  = '{16'hFF06, 1, 8'h5A, 8'h00, 1};
      vecs[7]  = '{16'hFF06, 0, 8'h00, 8'h5A, 1};
      vecs[8]  = '{16'hFF07, 1, 8'hFA, 8'hF8, 1};
      vecs[9]  = '{16'hFF07, 0, 8'h00, 8'hFA, 1};
      vecs[10] = '{16'hFF07, 1, 8'h00, 8'hFA, 1};
      vecs[11] = '{16'hFF07, 0, 8'h00, 8'hF8, 1};
      vecs[12] = '{16'hFF08, 1, 8'h12, 8'hFF, 0};
      vecs[13] = '{16'hFF06, 0, 8'h00, 8'h5A, 1};
      vecs[14] = '{16'h0000, 0, 8'h00, 8'hFF, 0};

      do_reset();
      foreach (vecs[i]) begin
         cyc(vecs[i].addr, vecs[i].wr, vecs[i].wd);
         chk($sformatf("vec%0d_data", i), int'(last_rd), int'(vecs[i].exp_do));
         chk($sformatf("vec%0d_hit", i), int'(hit), int'(vecs[i].exp_hit));
      end

      // DIV after exactly 256 clocks from reset release
      do_reset();
      repeat (256) cyc(A_DIV, 0, 8'h00);
      cyc(A_DIV, 0, 8'h00);
      chk("div_256", int'(last_rd), 8'h01);
      cyc(A_TIMA, 0, 8'h00);
      chk("tima_disabled", int'(last_rd), 8'h00);

      // Full overflow: FE -> FF -> 00 x4 -> F0 with a single interrupt
      setup_ovf(8'hF0);
      for (int i = 0; i < 40; i++) begin
         cyc(A_TIMA, 0, 8'h00);
         rd[i] = last_rd; irq[i] = last_int;
      end
      begin
         int p = -1, np = 0;
         for (int i = 0; i < 40; i++) if (irq[i]) begin np++; if (p < 0) p = i; end
         chk("ovf_irq_count", np, 1);
         chk("ovf_irq_cycle", p, 34);
         if (p >= 5 && p < 39) begin
            chk("ovf_reload_val", int'(rd[p]), 8'hF0);
            chk("ovf_after_reload", int'(rd[p + 1]), 8'hF0);
            for (int k = 1; k <= 4; k++) chk("ovf_wait_zero", int'(rd[p - k]), 8'h00);
            chk("ovf_pre_ff", int'(rd[p - 5]), 8'hFF);
         end else chk("ovf_irq_found", 0, 1);
      end

      // TIMA write on 2nd OVF_WAIT clock cancels reload and interrupt
      setup_ovf(8'hF0);
      wait_wait1("cancel_reach_wait");
      cyc(A_TIMA, 1, 8'h42);
      begin
         int nirq = 0, nbad = 0;
         for (int i = 0; i < 12; i++) begin
            cyc(A_TIMA, 0, 8'h00);
            nirq += int'(last_int);
            if (last_rd != 8'h42) nbad++;
         end
         chk("cancel_irq", nirq, 0);
         chk("cancel_tima_held", nbad, 0);
      end

      // DIV write with tap bit high gives one extra increment
      cyc(A_TAC, 1, 8'h00);
      cyc(A_DIV, 1, 8'h00);
      cyc(A_TAC, 1, 8'h05);
      cyc(A_TIMA, 1, 8'h10);
      repeat (7) cyc(A_DIV, 0, 8'h00);
      cyc(A_DIV, 0, 8'h00);
      chk("div_bit3_set", int'(last_rd), 8'h00);
      cyc(A_DIV, 1, 8'h99);
      cyc(A_TIMA, 0, 8'h00);
      chk("div_wr_before_inc", int'(last_rd), 8'h10);
      cyc(A_TIMA, 0, 8'h00);
      chk("div_wr_inc", int'(last_rd), 8'h11);

      // TMA write in RELOAD cycle is taken immediately
      setup_ovf(8'hF0);
      wait_rel("tma_reach_reload");
      cyc(A_TMA, 1, 8'h77);
      chk("reload_irq", int'(last_int), 1);
      cyc(A_TIMA, 0, 8'h00);
      chk("reload_tma_new", int'(last_rd), 8'h77);
      chk("reload_irq_once", int'(last_int), 0);

      // TIMA write in RELOAD cycle is ignored
      setup_ovf(8'hF0);
      wait_rel("tima_reach_reload");
      cyc(A_TIMA, 1, 8'h33);
      cyc(A_TIMA, 0, 8'h00);
      chk("reload_tima_wr_ignored", int'(last_rd), 8'hF0);

      // Reset during OVF_WAIT: no interrupt, all registers at reset values
      setup_ovf(8'hF0);
      wait_wait1("rst_reach_wait");
      cpu_addr = A_TIMA;
      reset = 1'b0;
      m_reset();
      @(negedge clock);
      chk("rst_irq_low", int'(timer_int), 0);
      chk("rst_tima_low", int'(data_out), 8'h00);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      cyc(A_TIMA, 0, 8'h00); chk("rst_tima", int'(last_rd), 8'h00);
      cyc(A_TMA, 0, 8'h00);  chk("rst_tma", int'(last_rd), 8'h00);
      cyc(A_TAC, 0, 8'h00);  chk("rst_tac", int'(last_rd), 8'hF8);
      cyc(A_DIV, 0, 8'h00);  chk("rst_div", int'(last_rd), 8'h00);
      begin
         int nirq = 0;
         for (int i = 0; i < 12; i++) begin cyc(A_TIMA, 0, 8'h00); nirq += int'(last_int); end
         chk("rst_no_irq", nirq, 0);
      end

      // Random bus traffic against the model
      for (int i = 0; i < 4000; i++) begin
         logic [15:0] a;
         logic [7:0]  d;
         bit          w;
         a = 16'hFF02 + 16'($urandom_range(0, 7));
         w = ($urandom_range(0, 5) == 0);
         d = 8'($urandom);
         if (a == A_TIMA && $urandom_range(0, 1) == 1) d = 8'hFF;
         if (a == A_TAC && $urandom_range(0, 1) == 1) d = 8'h05;
         cyc(a, w, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
